// File: rtl/bp_hazard_unit.sv
// Operand bypass select, load-use and multiply/divide-unit hazard detection for the decode stage.
// Optional stall performance counter is enabled by defining HAZ_PERF_CNT_EN.
module bp_hazard_unit #(
    parameter int unsigned AW      = 5,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned NSTG    = 3,
    parameter int unsigned MDU_LAT = 4,
    localparam int unsigned SW     = $clog2(NSTG + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSTG*AW-1:0]   stg_rd,
    input  logic [NSTG-1:0]      stg_wen,
    input  logic                 stg1_is_load,
    input  logic                 mdu_start,
    input  logic [AW-1:0]        mdu_rd,
    output logic [NSRC*SW-1:0]   bp_sel,
    output logic                 stall,
    output logic                 mdu_busy,
    output logic                 mdu_err,
    output logic [15:0]          stall_cnt
);

    localparam int unsigned CW = $clog2(MDU_LAT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_rd;
    logic             r_err;

    logic [NSRC*SW-1:0] w_bp_sel;
    logic               w_lu_haz;
    logic               w_mdu_haz;
    logic               w_stall;

    // Per-port bypass select plus both hazard sources; youngest matching stage wins.
    always_comb begin
        w_bp_sel  = '0;
        w_lu_haz  = 1'b0;
        w_mdu_haz = 1'b0;
        for (int p = 0; p < int'(NSRC); p++) begin
            if (src_addr[p*AW +: AW] != '0) begin
                for (int k = int'(NSTG); k >= 1; k--) begin
                    if (stg_wen[k-1] && (stg_rd[(k-1)*AW +: AW] == src_addr[p*AW +: AW])) begin
                        w_bp_sel[p*SW +: SW] = SW'(k);
                    end
                end
                if (src_valid[p]) begin
                    if (stg_wen[0] && stg1_is_load && (stg_rd[AW-1:0] == src_addr[p*AW +: AW])) begin
                        w_lu_haz = 1'b1;
                    end
                    if ((r_state == S_BUSY) && (r_rd == src_addr[p*AW +: AW])) begin
                        w_mdu_haz = 1'b1;
                    end
                end
            end
        end
    end

    assign w_stall = w_lu_haz | w_mdu_haz;

    // MDU tracker: issue only from IDLE; a start seen while BUSY is rejected with an error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mdu_start) begin
                        r_state <= S_BUSY;
                        r_rd    <= mdu_rd;
                        r_cnt   <= CW'(MDU_LAT - 1);
                    end
                end
                S_BUSY: begin
                    r_err <= mdu_start;
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

    assign bp_sel   = w_bp_sel;
    assign stall    = w_stall;
    assign mdu_busy = (r_state == S_BUSY);
    assign mdu_err  = r_err;

endmodule

// File: doc/bp_hazard_unit.md
BP_HAZARD_UNIT -- requirements
Module: bp_hazard_unit

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter AW, default 5, register address width.
REQ-002 The block SHALL have parameter NSRC, default 2, number of source operand ports.
REQ-003 The block SHALL have parameter NSTG, default 3, number of forwarding stages; stage 1 is the youngest (MEM).
REQ-004 The block SHALL have parameter MDU_LAT, default 4, multiply/divide unit latency in cycles, legal range 2..255.
REQ-005 The block SHALL derive local SW = clog2(NSTG+1) as the select width.

Ports, one per line: name, direction, width, meaning.
REQ-006 clk, in, 1: single clock; all state updates on its rising edge.
REQ-007 reset_n, in, 1: reset, asynchronous assert, active-low.
REQ-008 src_addr, in, NSRC*AW: source register specifiers; port i is at bits [i*AW +: AW].
REQ-009 src_valid, in, NSRC: source port i is read this cycle.
REQ-010 stg_rd, in, NSTG*AW: destination register of stage k+1 at bits [k*AW +: AW].
REQ-011 stg_wen, in, NSTG: stage k+1 will write its rd.
REQ-012 stg1_is_load, in, 1: the stage-1 instruction is a load, so its data is not yet available.
REQ-013 mdu_start, in, 1: MDU issue pulse.
REQ-014 mdu_rd, in, AW: MDU destination register.
REQ-015 bp_sel, out, NSRC*SW: per-port forwarding select; 0 = register file, k = stage k.
REQ-016 stall, out, 1: hold the decode stage.
REQ-017 mdu_busy, out, 1: an MDU operation is outstanding.
REQ-018 mdu_err, out, 1: one-cycle pulse when an issue is rejected.
REQ-019 stall_cnt, out, 16: stall cycle counter.

Function
REQ-020 bp_sel SHALL be combinational per port: 0 if src_addr is 0; otherwise the lowest k with stg_wen[k-1] set and stg_rd equal to src_addr; otherwise 0.
REQ-021 A load-use hazard SHALL be detected in the same cycle when any valid port has nonzero src_addr matching stage 1 while stg_wen[0] and stg1_is_load are both set.
REQ-022 On a load-use hazard, stall SHALL assert in that cycle, and bp_sel SHALL still report 1 for the matching port.
REQ-023 The MDU FSM SHALL have states IDLE and BUSY.
REQ-024 In IDLE, mdu_start SHALL latch mdu_rd, load the counter with MDU_LAT-1, and move the FSM to BUSY.
REQ-025 In BUSY, the counter SHALL decrement each cycle, and the FSM SHALL return to IDLE on the edge where the counter is 0.
REQ-026 mdu_busy SHALL be high exactly in BUSY, i.e. for MDU_LAT cycles after the start edge.
REQ-027 In BUSY, mdu_start SHALL be ignored, leaving state and counter unchanged, and mdu_err SHALL pulse high for the following cycle.
REQ-028 An MDU hazard SHALL be detected while BUSY when any valid port has nonzero src_addr equal to the latched rd.
REQ-029 stall SHALL be the OR of the load-use hazard and the MDU hazard.
REQ-030 A latched rd of 0 SHALL never cause a stall.
REQ-031 The counter width SHALL be clog2(MDU_LAT), and the counter SHALL never wrap below 0.
REQ-032 mdu_start in the same cycle as the BUSY-to-IDLE transition SHALL be rejected; issue is accepted only when the FSM is IDLE at the sampling edge.

Reset
REQ-033 reset_n low SHALL immediately force FSM=IDLE, counter=0, latched rd=0, mdu_err=0 and stall_cnt=0, with no clock required.
REQ-034 Reset asserted mid-operation SHALL abandon the outstanding MDU operation; mdu_busy and any MDU-caused stall SHALL drop asynchronously.
REQ-035 After release, the block SHALL accept mdu_start on the first rising edge.

Configuration
REQ-036 With macro HAZ_PERF_CNT_EN defined, stall_cnt SHALL increment on every edge where stall is high and SHALL saturate at 16'hFFFF.
REQ-037 Without HAZ_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-038 Defaults; src0=5, stg_rd={stage3=5, stage2=5, stage1=5}, stg_wen=3'b110 -> bp_sel port0=2, stall=0.
REQ-039 src0=0, all stages rd=0 with wen=1 -> bp_sel=0, stall=0.
REQ-040 src1=7 valid, stage1 rd=7, wen=1, is_load=1 -> stall=1, bp_sel port1=1; with src_valid=0 the same inputs give stall=0.
REQ-041 mdu_start with rd=9 at edge T -> mdu_busy high T+1..T+4; src0=9 valid -> stall high for those 4 cycles, then 0.
REQ-042 mdu_start at T+2 while busy -> mdu_err=1 at T+3 only, and busy still ends after T+4.
REQ-043 With HAZ_PERF_CNT_EN, a 3-cycle stall -> stall_cnt=3; reset_n low mid-BUSY -> mdu_busy=0 and stall_cnt=0 before the next edge.
